cuenta_regresiva: RTL

//  Countdown counterpart of the stopwatch digit chain: holds an m:ss.dc time as BCD digits
//  and decrements it one centesima per tick down to 0:00.00, then flags completion.

---
 rtl/cuenta_regresiva.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/cuenta_regresiva.sv
// BCD countdown timer (m:ss.dc): loads a preset, decrements one centesima per prescaled tick
// and pulses fin on the edge the count reaches 0:00.00.
module cuenta_regresiva #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       stay,
  input  logic [3:0] preset_unidadesMinuto,
  input  logic [2:0] preset_decenasSegundo,
  input  logic [3:0] preset_unidadesSegundo,
  input  logic [3:0] preset_decimas,
  input  logic [3:0] preset_centesimas,
  output logic [3:0] unidadesMinuto,
  output logic [2:0] decenasSegundo,
  output logic [3:0] unidadesSegundo,
  output logic [3:0] decimas,
  output logic [3:0] centesimas,
  output logic       running,
  output logic       fin
);

  localparam int unsigned PW = $clog2(TICK_DIV) + 1;
  localparam logic [PW-1:0] PresLast = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e        state_q, state_d;
  logic [3:0]    um_q, um_d;
  logic [2:0]    ds_q, ds_d;
  logic [3:0]    us_q, us_d;
  logic [3:0]    de_q, de_d;
  logic [3:0]    ce_q, ce_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          fin_q, fin_d;
  logic          running_q, running_d;

  logic       cnt_zero;
  logic       b_ce, b_de, b_us, b_ds;
  logic [3:0] um_dec, us_dec, de_dec, ce_dec;
  logic [2:0] ds_dec;
  logic       dec_zero;

  // Borrow chain: a digit borrows only when every digit below it is zero.
  always_comb begin
    cnt_zero = (um_q == 4'd0) && (ds_q == 3'd0) && (us_q == 4'd0) && (de_q == 4'd0)
               && (ce_q == 4'd0);
    b_ce   = (ce_q == 4'd0);
    b_de   = b_ce && (de_q == 4'd0);
    b_us   = b_de && (us_q == 4'd0);
    b_ds   = b_us && (ds_q == 3'd0);
    ce_dec = b_ce ? 4'd9 : ce_q - 4'd1;
    de_dec = b_ce ? (b_de ? 4'd9 : de_q - 4'd1) : de_q;
    us_dec = b_de ? (b_us ? 4'd9 : us_q - 4'd1) : us_q;
    ds_dec = b_us ? (b_ds ? 3'd5 : ds_q - 3'd1) : ds_q;
    um_dec = b_ds ? um_q - 4'd1 : um_q;
    dec_zero = (um_dec == 4'd0) && (ds_dec == 3'd0) && (us_dec == 4'd0) && (de_dec == 4'd0)
               && (ce_dec == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      um_q      <= '0;
      ds_q      <= '0;
      us_q      <= '0;
      de_q      <= '0;
      ce_q      <= '0;
      presc_q   <= '0;
      fin_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      um_q      <= um_d;
      ds_q      <= ds_d;
      us_q      <= us_d;
      de_q      <= de_d;
      ce_q      <= ce_d;
      presc_q   <= presc_d;
      fin_q     <= fin_d;
      running_q <= running_d;
    end
  end

  always_comb begin
    state_d = state_q;
    um_d    = um_q;
    ds_d    = ds_q;
    us_d    = us_q;
    de_d    = de_q;
    ce_d    = ce_q;
    presc_d = presc_q;
    fin_d   = 1'b0;
    if (load) begin
      um_d    = (preset_unidadesMinuto > 4'd9) ? 4'd9 : preset_unidadesMinuto;
      ds_d    = (preset_decenasSegundo > 3'd5) ? 3'd5 : preset_decenasSegundo;
      us_d    = (preset_unidadesSegundo > 4'd9) ? 4'd9 : preset_unidadesSegundo;
      de_d    = (preset_decimas > 4'd9) ? 4'd9 : preset_decimas;
      ce_d    = (preset_centesimas > 4'd9) ? 4'd9 : preset_centesimas;
      presc_d = '0;
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (stay && !cnt_zero) state_d = StRun;
        end
        StRun: begin
          if (!stay) begin
            state_d = StPause;
          end else if (presc_q == PresLast) begin
            presc_d = '0;
            um_d    = um_dec;
            ds_d    = ds_dec;
            us_d    = us_dec;
            de_d    = de_dec;
            ce_d    = ce_dec;
            if (dec_zero) begin
              state_d = StDone;
              fin_d   = 1'b1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        StPause: begin
          // Prescaler is left as-is so the interrupted tick resumes.
          if (stay) state_d = StRun;
        end
        StDone: begin
          state_d = StDone;
        end
        default: state_d = StIdle;
      endcase
    end
    running_d = (state_d == StRun);
  end

  always_comb begin
    unidadesMinuto  = um_q;
    decenasSegundo  = ds_q;
    unidadesSegundo = us_q;
    decimas         = de_q;
    centesimas      = ce_q;
    running         = running_q;
    fin             = fin_q;
  end

endmodule
